led_pulse: RTL and testbench

LED_PULSE -- requirements
Module: led_pulse

---
 rtl/led_pulse.sv | 179 +++++++++++++++++
 tb/tb_led_pulse.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/led_pulse.sv
// led_pulse: plays N blinks on an active-low LED when a trigger arrives.
// A 1 ms prescaler plus a ms counter time each FSM state; outputs are
// registered from the next state so they change on the same edge as the
// state register.
// Optional build macro LED_PULSE_QUEUE_EN adds a 4-deep request FIFO that
// holds triggers arriving while a sequence plays; queued sequences are
// separated by an OFF_MS dark gap.
module led_pulse #(
    parameter int TICK_DIV = 50000,
    parameter int ON_MS    = 100,
    parameter int OFF_MS   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [3:0] count_in,
    output logic       led_out,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    localparam int MS_MAX = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW     = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] ON_LAST    = MW'(ON_MS - 1);
    localparam logic [MW-1:0] OFF_LAST   = MW'(OFF_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ON,
        OFF,
        GAP,
        END
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            state_change;

    logic [PW-1:0]   presc;
    logic [MW-1:0]   ms;
    logic [3:0]      remaining;

    logic            req;
    logic            tick_last;
    logic            on_done;
    logic            off_done;

    logic            pop;
    logic            queue_pending;
    logic [3:0]      q_head;

    assign req       = trig && (count_in != 4'd0);
    assign tick_last = (presc == PRESC_LAST);
    assign on_done   = tick_last && (ms == ON_LAST);
    assign off_done  = tick_last && (ms == OFF_LAST);

    // GAP exit is the only point where the queue head is consumed.
    assign pop       = (state == GAP) && off_done;

`ifdef LED_PULSE_QUEUE_EN
    logic [3:0] q_mem [4];
    logic [1:0] q_rd;
    logic [1:0] q_wr;
    logic [2:0] q_cnt;
    logic       push;
    logic       push_ok;
    logic       q_full;

    assign push    = req && (state != IDLE);
    assign q_full  = (q_cnt == 3'd4);
    // A pop in the same cycle frees a slot, so a full queue still accepts it.
    assign push_ok = push && (!q_full || pop);
    // A request queued during END itself must also divert END into GAP.
    assign queue_pending = (q_cnt != 3'd0) || push_ok;
    assign q_head  = q_mem[q_rd];

    // Request FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            q_rd  <= '0;
            q_wr  <= '0;
            q_cnt <= '0;
        end else begin
            if (push_ok) begin
                q_mem[q_wr] <= count_in;
                q_wr        <= q_wr + 1'b1;
            end
            if (pop) begin
                q_rd <= q_rd + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Sticky overflow flag for requests dropped on a full queue
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (push && !push_ok) begin
            ovf <= 1'b1;
        end
    end
`else
    assign queue_pending = 1'b0;
    assign q_head        = 4'd0;
    assign ovf           = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req) next_state = ON;
            ON:   if (on_done) next_state = (remaining > 4'd1) ? OFF : END;
            OFF:  if (off_done) next_state = ON;
            GAP:  if (off_done) next_state = ON;
            END:  next_state = queue_pending ? GAP : IDLE;
            default: next_state = IDLE;
        endcase
        state_change = (next_state != state);
    end

    // Prescaler and ms counter, restarted on every state entry
    always_ff @(posedge clk) begin
        if (rst || state_change || (state == IDLE) || (state == END)) begin
            presc <= '0;
            ms    <= '0;
        end else if (tick_last) begin
            presc <= '0;
            ms    <= ms + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Remaining blink count: load on start, decrement after each OFF, reload from queue
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if ((state == IDLE) && req) begin
            remaining <= count_in;
        end else if ((state == OFF) && off_done) begin
            remaining <= remaining - 1'b1;
        end else if (pop) begin
            remaining <= q_head;
        end
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            led_out <= (next_state != ON);
            busy    <= (next_state != IDLE);
            done    <= (next_state == END);
        end
    end

endmodule

// File: tb/tb_led_pulse.sv
// tb_led_pulse: directed bench for led_pulse with TICK_DIV=4, ON_MS=2,
// OFF_MS=3 (ON = 8 cycles, OFF/GAP = 12 cycles). Inputs are driven and
// outputs sampled 1 ns after each rising edge. Build with
// LED_PULSE_QUEUE_EN defined to exercise the queue variant.
module tb_led_pulse;

    logic       clk;
    logic       rst;
    logic       trig;
    logic [3:0] count_in;
    logic       led_out;
    logic       busy;
    logic       done;
    logic       ovf;

    int n_tests;
    int n_fail;

    bit exp_led[$];
    bit exp_done[$];

    led_pulse #(
        .TICK_DIV(4),
        .ON_MS   (2),
        .OFF_MS  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .count_in(count_in),
        .led_out (led_out),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_led"}, led_out, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    task automatic add_seg(input bit led, input bit dn, input int len);
        for (int k = 0; k < len; k++) begin
            exp_led.push_back(led);
            exp_done.push_back(dn);
        end
    endtask

    // Expected waveform of one N-blink sequence, ending with its END cycle.
    task automatic add_blinks(input int n);
        for (int b = 0; b < n; b++) begin
            add_seg(1'b0, 1'b0, 8);
            if (b != n - 1) add_seg(1'b1, 1'b0, 12);
        end
        add_seg(1'b1, 1'b1, 1);
    endtask

    // Caller has already driven the starting trig. Plays the expected
    // waveform cycle by cycle, holding trig high with inj_cnt for samples
    // inj_s..inj_e, then checks the return to idle.
    task automatic run_expect(input string tag, input int inj_s, input int inj_e,
                              input logic [3:0] inj_cnt);
        for (int i = 1; i <= exp_led.size(); i++) begin
            tick();
            if (i >= inj_s && i <= inj_e) begin
                trig     = 1'b1;
                count_in = inj_cnt;
            end else begin
                trig     = 1'b0;
                count_in = 4'd0;
            end
            check({tag, "_led"}, led_out, exp_led[i-1]);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_done"}, done, exp_done[i-1]);
        end
        tick();
        trig     = 1'b0;
        count_in = 4'd0;
        check_idle({tag, "_end"});
        exp_led.delete();
        exp_done.delete();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        trig     = 1'b0;
        count_in = 4'd0;
        tick();
        tick();
        check_idle("reset");
        check("reset_ovf", ovf, 1'b0);
        rst = 1'b0;
        tick();

        // Single blink: 8 lit cycles then END with done.
        trig = 1'b1;
        count_in = 4'd1;
        add_blinks(1);
        run_expect("one", 0, -1, 4'd0);

        // count_in = 0 in IDLE must be ignored.
        trig = 1'b1;
        count_in = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            trig = 1'b0;
            check_idle("zero");
        end

        // Three blinks: 8/12/8/12/8 then END, 49 busy cycles.
        trig = 1'b1;
        count_in = 4'd3;
        add_blinks(3);
        run_expect("three", 0, -1, 4'd0);

`ifdef LED_PULSE_QUEUE_EN
        // One blink playing, five 2-blink requests while busy: four queued,
        // fifth dropped; each queued sequence preceded by a 12-cycle GAP.
        trig = 1'b1;
        count_in = 4'd1;
        add_blinks(1);
        for (int q = 0; q < 4; q++) begin
            add_seg(1'b1, 1'b0, 12);
            add_blinks(2);
        end
        check("q_ovf_before", ovf, 1'b0);
        run_expect("queue", 1, 5, 4'd2);
        check("q_ovf_after", ovf, 1'b1);
`else
        // Triggers held high while busy and through END are all ignored.
        trig = 1'b1;
        count_in = 4'd2;
        add_blinks(2);
        run_expect("noq", 3, 29, 4'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("noq_after");
        end
        check("noq_ovf", ovf, 1'b0);
`endif

        // Reset during the second ON of a 3-blink sequence (samples 21..28),
        // with a simultaneous trig that reset must override.
        trig = 1'b1;
        count_in = 4'd3;
        for (int i = 1; i <= 24; i++) begin
            tick();
            trig = 1'b0;
            count_in = 4'd0;
            check("rst_seq_led", led_out, (i <= 8 || i >= 21) ? 1'b0 : 1'b1);
            check("rst_seq_busy", busy, 1'b1);
        end
        rst = 1'b1;
        trig = 1'b1;
        count_in = 4'd2;
        tick();
        rst = 1'b0;
        trig = 1'b0;
        count_in = 4'd0;
        check_idle("abort");
        check("abort_ovf", ovf, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle("abort_after");
        end

        // Normal start after the abort.
        trig = 1'b1;
        count_in = 4'd1;
        add_blinks(1);
        run_expect("restart", 0, -1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
